// File: rtl/inst_fetch_if.sv
// Decode-side handshake of the fetch unit: {inst, pc} presented over valid/ready.
// The fetch unit drives the master side; decode is the slave.
interface inst_fetch_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (output inst_valid, inst, inst_pc, input inst_ready);
  modport slave  (input inst_valid, inst, inst_pc, output inst_ready);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, addresses the registered-output ROM and buffers {inst, pc} for decode.
// Define INST_FETCH_SKID_EN for a 2-entry buffer (one per cycle); default is a single output register.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  output logic [31:0]  rom_addr,
  input  logic [31:0]  rom_data,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  inst_fetch_if.master dec,
  output logic         misalign_err
);

`ifdef INST_FETCH_SKID_EN
  localparam logic [2:0] DEPTH = 3'd2;
`else
  localparam logic [2:0] DEPTH = 3'd1;
`endif

  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        pend;
  logic [1:0]  count;
  logic [31:0] head_inst;
  logic [31:0] head_pc;
`ifdef INST_FETCH_SKID_EN
  logic [31:0] tail_inst;
  logic [31:0] tail_pc;
`endif
  logic        pop;
  logic        issue;
  logic [2:0]  occ;

  assign pop            = dec.inst_valid & dec.inst_ready;
  assign rom_addr       = pc;
  assign dec.inst_valid = (count != 2'd0);
  assign dec.inst       = head_inst;
  assign dec.inst_pc    = head_pc;

  // The in-flight word lands next edge, so it already claims a slot when deciding to issue.
  always_comb begin
    occ   = {1'b0, count} - {2'b00, pop} + {2'b00, pend};
    issue = (occ < DEPTH);
  end

  // NOTE: every register here is state updated on the clock edge, so it uses <= only;
  // blocking assignments would let later statements see this edge's new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      pend         <= 1'b0;
      pend_pc      <= 32'h0;
      count        <= 2'd0;
      misalign_err <= 1'b0;
      head_inst    <= 32'h0;
      head_pc      <= 32'h0;
`ifdef INST_FETCH_SKID_EN
      tail_inst    <= 32'h0;
      tail_pc      <= 32'h0;
`endif
    end else if (redirect_valid) begin
      pc           <= {redirect_pc[31:2], 2'b00};
      pend         <= 1'b0;
      count        <= 2'd0;
      misalign_err <= |redirect_pc[1:0];
    end else begin
      misalign_err <= 1'b0;
      count        <= count + {1'b0, pend} - {1'b0, pop};

      if (issue) begin
        pend    <= 1'b1;
        pend_pc <= pc;
        pc      <= pc + 32'd4;
      end else begin
        pend    <= 1'b0;
      end

`ifdef INST_FETCH_SKID_EN
      // Two-slot shift buffer: head is what decode sees, tail backs it up during a stall.
      if (pop) begin
        if (count == 2'd2) begin
          head_inst <= tail_inst;
          head_pc   <= tail_pc;
          if (pend) begin
            tail_inst <= rom_data;
            tail_pc   <= pend_pc;
          end
        end else if (pend) begin
          head_inst <= rom_data;
          head_pc   <= pend_pc;
        end
      end else if (pend) begin
        if (count == 2'd0) begin
          head_inst <= rom_data;
          head_pc   <= pend_pc;
        end else begin
          tail_inst <= rom_data;
          tail_pc   <= pend_pc;
        end
      end
`else
      // A word only lands when the single register is empty or being popped this edge.
      if (pend) begin
        head_inst <= rom_data;
        head_pc   <= pend_pc;
      end
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: two instances (RESET_PC 0 and 32'hFFFF_FFFC) on a preloaded ROM model,
// a queue-level reference model compared every cycle, plus directed literal expectations.
module tb_inst_fetch;

`ifdef INST_FETCH_SKID_EN
  localparam int          DEPTH      = 2;
  localparam int          GAP        = 1;
  localparam logic [31:0] STALL_ADDR = 32'h8;
`else
  localparam int          DEPTH      = 1;
  localparam int          GAP        = 2;
  localparam logic [31:0] STALL_ADDR = 32'h4;
`endif

  localparam logic [31:0] W0 = 32'h00c2_0213;
  localparam logic [31:0] W4 = 32'h0070_8093;
  localparam logic [31:0] W8 = 32'h0051_0113;
  localparam logic [31:0] WC = 32'h0201_8193;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv;
  logic [31:0] rpc;
  logic        ready;
  logic [31:0] rom_addr0, rom_addr1;
  logic [31:0] rom_q0 = 32'h0;
  logic [31:0] rom_q1 = 32'h0;
  logic        mis0, mis1;

  int checks = 0;
  int errors = 0;

  inst_fetch_if d0_if ();
  inst_fetch_if d1_if ();
  assign d0_if.inst_ready = ready;
  assign d1_if.inst_ready = 1'b1;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .rom_addr(rom_addr0), .rom_data(rom_q0),
    .redirect_valid(rv), .redirect_pc(rpc), .dec(d0_if), .misalign_err(mis0)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .rom_addr(rom_addr1), .rom_data(rom_q1),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .dec(d1_if), .misalign_err(mis1)
  );

  always #5 clk = ~clk;

  // ROM: registered read; unmapped addresses keep the previous output.
  function automatic logic [31:0] rom_word(input logic [31:0] a, input logic [31:0] prev);
    case (a)
      32'h0:   return W0;
      32'h4:   return W4;
      32'h8:   return W8;
      32'hC:   return WC;
      default: return prev;
    endcase
  endfunction

  always @(posedge clk) begin
    rom_q0 <= rom_word(rom_addr0, rom_q0);
    rom_q1 <= rom_word(rom_addr1, rom_q1);
  end

  // Reference model: PC, one in-flight fetch, and an ordered list of buffered {inst, pc}.
  bit          m_ok   [2] = '{1'b0, 1'b0};
  bit          m_pend [2];
  bit          m_mis  [2];
  int          m_cnt  [2];
  logic [31:0] m_pc     [2];
  logic [31:0] m_pend_pc[2];
  logic [31:0] m_qi [2][2];
  logic [31:0] m_qp [2][2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input logic [31:0] rst_pc, input logic r,
                            input logic rv_i, input logic [31:0] rpc_i, input logic rdy,
                            input logic [31:0] word);
    bit pop_m;
    int room;
    if (r) begin
      m_ok[k]   = 1'b1;
      m_pc[k]   = rst_pc;
      m_pend[k] = 1'b0;
      m_cnt[k]  = 0;
      m_mis[k]  = 1'b0;
    end else if (m_ok[k]) begin
      pop_m = (m_cnt[k] > 0) && (rdy === 1'b1);
      if (rv_i) begin
        m_pc[k]   = {rpc_i[31:2], 2'b00};
        m_pend[k] = 1'b0;
        m_cnt[k]  = 0;
        m_mis[k]  = |rpc_i[1:0];
      end else begin
        room = DEPTH - (m_cnt[k] - (pop_m ? 1 : 0) + (m_pend[k] ? 1 : 0));
        if (pop_m) begin
          m_qi[k][0] = m_qi[k][1];
          m_qp[k][0] = m_qp[k][1];
          m_cnt[k]--;
        end
        if (m_pend[k] && m_cnt[k] < 2) begin
          m_qi[k][m_cnt[k]] = word;
          m_qp[k][m_cnt[k]] = m_pend_pc[k];
          m_cnt[k]++;
        end
        if (room > 0) begin
          m_pend_pc[k] = m_pc[k];
          m_pc[k]      = m_pc[k] + 32'd4;
          m_pend[k]    = 1'b1;
        end else begin
          m_pend[k]    = 1'b0;
        end
        m_mis[k] = 1'b0;
      end
    end
  endtask

  // NOTE: the model runs in the active region of the edge, so it sees the ROM output
  // from before this edge, exactly like the DUT's rom_data input.
  always @(posedge clk) begin
    model_step(0, 32'h0000_0000, rst, rv, rpc, ready, rom_q0);
    model_step(1, 32'hFFFF_FFFC, rst, 1'b0, 32'h0, 1'b1, rom_q1);
  end

  task automatic cmp(input int k, input logic [31:0] addr, input logic v,
                     input logic [31:0] ins, input logic [31:0] ipc, input logic mis);
    if (m_ok[k]) begin
      check($sformatf("d%0d_rom_addr", k), addr, m_pc[k]);
      check($sformatf("d%0d_inst_valid", k), {31'b0, v}, {31'b0, m_cnt[k] > 0});
      check($sformatf("d%0d_misalign", k), {31'b0, mis}, {31'b0, m_mis[k]});
      if (m_cnt[k] > 0) begin
        check($sformatf("d%0d_inst", k), ins, m_qi[k][0]);
        check($sformatf("d%0d_inst_pc", k), ipc, m_qp[k][0]);
      end
    end
  endtask

  always @(negedge clk) begin
    cmp(0, rom_addr0, d0_if.inst_valid, d0_if.inst, d0_if.inst_pc, mis0);
    cmp(1, rom_addr1, d1_if.inst_valid, d1_if.inst, d1_if.inst_pc, mis1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance until dut0 shows a valid head (bounded), then pin gap, pc and word.
  task automatic next_entry(input string name, input int gap, input logic [31:0] pc,
                            input logic [31:0] ins);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (d0_if.inst_valid !== 1'b1 && n < 8);
    check({name, "_gap"}, n, gap);
    check({name, "_pc"}, d0_if.inst_pc, pc);
    check({name, "_inst"}, d0_if.inst, ins);
  endtask

  initial begin
    rst = 1'b1; rv = 1'b0; rpc = 32'h0; ready = 1'b1;
    step(3);
    check("rst_valid", {31'b0, d0_if.inst_valid}, 32'h0);
    check("rst_addr", rom_addr0, 32'h0);
    check("rst_addr_hi", rom_addr1, 32'hFFFF_FFFC);

    // Reset release streaming, both instances in lockstep.
    rst = 1'b0;
    next_entry("s1_e0", 2, 32'h0, W0);
    check("s5_pc0", d1_if.inst_pc, 32'hFFFF_FFFC);
    next_entry("s1_e1", GAP, 32'h4, W4);
    check("s5_pc1", d1_if.inst_pc, 32'h0);
    check("s5_inst1", d1_if.inst, W0);
    next_entry("s1_e2", GAP, 32'h8, W8);
    check("s5_pc2", d1_if.inst_pc, 32'h4);

    // Decode stall for 5 cycles with head 0x0, then zero-bubble resume.
    rst = 1'b1; ready = 1'b0;
    step(2);
    rst = 1'b0;
    next_entry("s2_head", 2, 32'h0, W0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("s2_hold_valid", {31'b0, d0_if.inst_valid}, 32'h1);
      check("s2_hold_pc", d0_if.inst_pc, 32'h0);
      check("s2_hold_inst", d0_if.inst, W0);
      check("s2_hold_addr", rom_addr0, STALL_ADDR);
    end
    ready = 1'b1;
    next_entry("s2_r1", GAP, 32'h4, W4);
    next_entry("s2_r2", GAP, 32'h8, W8);

    // Redirect to 0xc while 0x4 is buffered, with a pop on the same edge.
    rst = 1'b1; ready = 1'b0;
    step(2);
    rst = 1'b0;
    next_entry("s3_head", 2, 32'h0, W0);
    step(1);
    rv = 1'b1; rpc = 32'hC; ready = 1'b1;
    step(1);
    rv = 1'b0;
    check("s3_e0_valid", {31'b0, d0_if.inst_valid}, 32'h0);
    check("s3_e0_addr", rom_addr0, 32'hC);
    check("s3_e0_mis", {31'b0, mis0}, 32'h0);
    next_entry("s3_tgt", 2, 32'hC, WC);

    // Misaligned redirect: one-cycle error pulse, fetch from the aligned address.
    rv = 1'b1; rpc = 32'hA;
    step(1);
    rv = 1'b0;
    check("s4_mis_hi", {31'b0, mis0}, 32'h1);
    check("s4_addr", rom_addr0, 32'h8);
    check("s4_valid", {31'b0, d0_if.inst_valid}, 32'h0);
    step(1);
    check("s4_mis_lo", {31'b0, mis0}, 32'h0);
    next_entry("s4_tgt", 1, 32'h8, W8);

    // Reset mid-stream with the buffer filled, then the reset-release stream again.
    ready = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
    check("s6_valid", {31'b0, d0_if.inst_valid}, 32'h0);
    check("s6_addr", rom_addr0, 32'h0);
    ready = 1'b1;
    step(1);
    rst = 1'b0;
    next_entry("s6_e0", 2, 32'h0, W0);
    next_entry("s6_e1", GAP, 32'h4, W4);
    next_entry("s6_e2", GAP, 32'h8, W8);

    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
